// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl
//   Time-multiplexed scan controller for a bank of common-anode
//   seven-segment digits. A prescaler divides the clock into digit slots.
//   Each slot starts with one guard cycle with all anodes off, to avoid
//   ghosting. The rest of the slot shows the current digit from a shadow
//   copy of the display data. The shadow copy is captured only on load.
//
// Parameters
//   NUM_DIGITS   number of digits, 1..8
//   REFRESH_DIV  clock cycles per digit slot, >= 2
//
// Ports
//   ClkPort     in   system clock
//   Reset       in   synchronous active-high reset
//   load        in   strobe: capture value/dp_mask/en_mask/lzb_en
//   value       in   4*NUM_DIGITS hex nibbles, digit 0 in [3:0]
//   dp_mask     in   per-digit decimal point enable
//   en_mask     in   per-digit enable (0 = blank)
//   lzb_en      in   leading-zero blanking enable
//   an          out  anode selects, active low
//   seg         out  cathodes a..g on bits 0..6, active low
//   dp          out  decimal-point cathode, active low
//   frame_done  out  one-cycle pulse after the scan wraps to digit 0
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    ClkPort,
  input  logic                    Reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   en_mask,
  input  logic                    lzb_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;

  // Shadow copy of the display data
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dp_mask;
  logic [NUM_DIGITS-1:0]   r_en_mask;
  logic                    r_lzb;

  // Registered outputs
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_wrap;
  logic                    w_guard;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [NUM_DIGITS-1:0]   w_nz;
  logic [3:0]              w_nib;
  logic [IDX_W-1:0]        w_msn;
  logic                    w_en_cur;
  logic                    w_dp_cur;
  logic                    w_blank;
  logic [6:0]              w_seg_dec;

  assign w_tick  = (r_cnt == LAST_CNT);
  assign w_wrap  = w_tick && (r_idx == LAST_IDX);
  assign w_guard = (r_cnt == '0);

  // Per-digit select and nonzero flags
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_onehot[gi] = (r_idx == IDX_W'(gi));
      assign w_nz[gi]     = |r_value[4*gi +: 4];
    end
  endgenerate

  // Mux the nibble of the current digit. The one-hot select avoids
  // variable part-selects whose width depends on NUM_DIGITS.
  always_comb begin
    w_nib = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_onehot[i]) w_nib = r_value[4*i +: 4];
    end
  end

  // Find the most significant nonzero digit. The highest index wins.
  // An all-zero value leaves this at 0, so digit 0 always stays lit.
  always_comb begin
    w_msn = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_nz[i]) w_msn = IDX_W'(i);
    end
  end

  assign w_en_cur = |(r_en_mask & w_onehot);
  assign w_dp_cur = |(r_dp_mask & w_onehot);
  assign w_blank  = !w_en_cur || (r_lzb && (r_idx > w_msn));

  // Hex to seven-segment decoder, active low, bits g..a
  always_comb begin
    case (w_nib)
      4'h0:    w_seg_dec = 7'b1000000;
      4'h1:    w_seg_dec = 7'b1111001;
      4'h2:    w_seg_dec = 7'b0100100;
      4'h3:    w_seg_dec = 7'b0110000;
      4'h4:    w_seg_dec = 7'b0011001;
      4'h5:    w_seg_dec = 7'b0010010;
      4'h6:    w_seg_dec = 7'b0000010;
      4'h7:    w_seg_dec = 7'b1111000;
      4'h8:    w_seg_dec = 7'b0000000;
      4'h9:    w_seg_dec = 7'b0010000;
      4'hA:    w_seg_dec = 7'b0001000;
      4'hB:    w_seg_dec = 7'b0000011;
      4'hC:    w_seg_dec = 7'b1000110;
      4'hD:    w_seg_dec = 7'b0100001;
      4'hE:    w_seg_dec = 7'b0000110;
      default: w_seg_dec = 7'b0001110;
    endcase
  end

  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_value      <= '0;
      r_dp_mask    <= '0;
      r_en_mask    <= '0;
      r_lzb        <= 1'b0;
      r_an         <= '1;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      // Prescaler and digit index
      if (w_tick) begin
        r_cnt <= '0;
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // A load does not touch the scan position. It only changes what
      // the current and following digits show.
      if (load) begin
        r_value   <= value;
        r_dp_mask <= dp_mask;
        r_en_mask <= en_mask;
        r_lzb     <= lzb_en;
      end

      r_frame_done <= w_wrap;

      // The first cycle of each slot is the guard gap. All anodes are off,
      // and seg/dp are forced dark too.
      if (w_guard) begin
        r_an  <= '1;
        r_seg <= 7'h7F;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~w_onehot;
        r_seg <= w_blank ? 7'h7F : w_seg_dec;
        r_dp  <= ~w_dp_cur;
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
module tb_ssd_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  en_mask;
  logic        lzb_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  ssd_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .ClkPort    (clk),
    .Reset      (rst),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .en_mask    (en_mask),
    .lzb_en     (lzb_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    bit         chk_seg;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Hand-written expected seg/dp per digit (index = digit number)
  logic [6:0] seg_tab [4];
  logic       dp_tab  [4];
  int         k;  // output edge count since the last reset release

  localparam logic [6:0] BLK = 7'b1111111;

  task automatic chk(input string tag, input string name,
                     input logic [6:0] act, input logic [6:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s.%s act=%b req=%b", tag, name, act, req);
    end
  endtask

  // Monitor: one output per clock, compared against the next queued entry
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.tag, "an", {3'b000, an}, {3'b000, e.an});
        chk(e.tag, "dp", {6'b0, dp}, {6'b0, e.dp});
        chk(e.tag, "frame_done", {6'b0, frame_done}, {6'b0, e.fd});
        if (e.chk_seg) chk(e.tag, "seg", seg, e.seg);
        $display("edge k=%0d %s an=%b seg=%b dp=%b fd=%b", k, e.tag, an, seg, dp, frame_done);
      end
    end
  end

  // Queue the expected output for the next edge, then advance one cycle.
  // The output at edge k comes from the state in the cycle before it:
  // cnt=(k-1)%4, idx=((k-1)/4)%4. frame_done is high after every 16th edge.
  task automatic cyc(input string tag);
    exp_t e;
    int   c;
    int   id;
    c  = k % 4;
    id = (k / 4) % 4;
    k  = k + 1;
    e.tag     = tag;
    e.fd      = ((k % 16) == 0);
    e.chk_seg = (c != 0);
    if (c == 0) begin
      e.an  = 4'b1111;
      e.seg = BLK;
      e.dp  = 1'b1;
    end else begin
      e.an  = ~(4'b0001 << id);
      e.seg = seg_tab[id];
      e.dp  = dp_tab[id];
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic rst_cyc(input string tag);
    exp_t e;
    e.tag = tag; e.an = 4'b1111; e.seg = BLK; e.dp = 1'b1; e.fd = 1'b0;
    e.chk_seg = 1'b1;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic blank_tabs();
    seg_tab = '{BLK, BLK, BLK, BLK};
    dp_tab  = '{1'b1, 1'b1, 1'b1, 1'b1};
  endtask

  initial begin
    k = 0;
    blank_tabs();
    // Reset together with a load. The load must be discarded.
    rst = 1'b1; load = 1'b1; value = 16'h12AF; en_mask = 4'hF;
    dp_mask = 4'h0; lzb_en = 1'b0;
    @(negedge clk);
    rst_cyc("rst_load");
    rst_cyc("rst_load");
    rst = 1'b0; load = 1'b0; k = 0;
    run(16, "post_rst");                      // shadow still 0: all blank

    // Load 12AF at a slot boundary
    value = 16'h12AF; en_mask = 4'hF; dp_mask = 4'h0; lzb_en = 1'b0;
    load = 1'b1; cyc("load12AF"); load = 1'b0;
    seg_tab = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    run(31, "scan12AF");                      // k = 48

    // Input change without load must not reach the outputs
    value = 16'h0000; en_mask = 4'h0; dp_mask = 4'hF;
    run(16, "noload");                        // k = 64
    run(2, "pre_mid");                        // next edge has cnt=2, idx=0

    // Mid-slot load with leading-zero blanking of 0050
    value = 16'h0050; en_mask = 4'hF; dp_mask = 4'h0; lzb_en = 1'b1;
    load = 1'b1; cyc("midload"); load = 1'b0;
    seg_tab = '{7'b1000000, 7'b0010010, BLK, BLK};
    run(45, "lzb0050");                       // k = 112

    // All-zero value under blanking: only digit 0 shows "0"
    value = 16'h0000;
    load = 1'b1; cyc("lzb0"); load = 1'b0;
    seg_tab = '{7'b1000000, BLK, BLK, BLK};
    run(15, "lzb0");                          // k = 128

    // Decimal point on a disabled digit
    value = 16'h1234; lzb_en = 1'b0; en_mask = 4'b1011; dp_mask = 4'b0100;
    load = 1'b1; cyc("dp"); load = 1'b0;
    seg_tab = '{7'b0011001, 7'b0110000, BLK, 7'b1111001};
    dp_tab  = '{1'b1, 1'b1, 1'b0, 1'b1};
    run(17, "dp");                            // k = 146, next edge cnt=2

    // Reset mid-slot with a simultaneous load
    rst = 1'b1; load = 1'b1; value = 16'h12AF; en_mask = 4'hF;
    dp_mask = 4'hF; lzb_en = 1'b1;
    rst_cyc("rst_mid");
    rst = 1'b0; load = 1'b0; k = 0;
    blank_tabs();
    run(16, "post_rst2");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending=%0d req=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed seven-segment digits, legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, ClkPort cycles per digit slot, legal range >= 2.
REQ-003 SHALL have ports, clock and reset first, one per line:
- ClkPort  in  1  system clock; the block's only clock.
- Reset  in  1  synchronous, active-high reset.
- load  in  1  single-cycle strobe that captures value, dp_mask, en_mask and lzb_en into the shadow registers.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i [4i+3:4i] is digit i, digit 0 rightmost.
- dp_mask  in  NUM_DIGITS  bit i=1 lights the decimal point of digit i.
- en_mask  in  NUM_DIGITS  bit i=0 forces digit i blank.
- lzb_en  in  1  leading-zero blanking enable.
- an  out  NUM_DIGITS  anode selects, active low.
- seg  out  7  cathodes, active low; seg[0]=Ca ... seg[6]=Cg.
- dp  out  1  decimal-point cathode, active low.
- frame_done  out  1  one-cycle pulse when the scan wraps back to digit 0.

Function
REQ-004 SHALL keep prescaler cnt counting 0..REFRESH_DIV-1 and wrapping to 0; the slot tick is cnt==REFRESH_DIV-1.
REQ-005 SHALL advance digit index idx by 1 on each slot tick; the step from NUM_DIGITS-1 SHALL wrap idx to 0.
REQ-006 SHALL assert frame_done for exactly one cycle, the cycle after the tick on which idx wraps to 0; NUM_DIGITS=1 SHALL pulse it every slot.
REQ-007 SHALL update the shadow registers only on load=1 and display only shadow contents, so unstrobed input changes never reach the outputs.
REQ-008 SHALL register an, seg and dp; each cycle they SHALL reflect the cnt, idx and shadow values of the previous cycle (1-cycle latency).
REQ-009 SHALL make load visible on outputs two edges after the load cycle; a load mid-slot SHALL change the current digit without resetting cnt or idx.
REQ-010 SHALL drive an to all ones (guard gap) for the output cycle derived from cnt==0 in every slot.
REQ-011 SHALL otherwise drive an with only bit idx low.
REQ-012 SHALL decode nibbles with the standard hex table (active low, g..a):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
REQ-013 SHALL blank a digit (seg=1111111, an unchanged) when its en_mask bit is 0.
REQ-014 SHALL, when lzb_en=1, blank every digit above the most significant nonzero nibble.
REQ-015 SHALL never blank digit 0 under lzb_en, so an all-zero value shows a single "0".
REQ-016 SHALL drive dp=~dp_mask[idx] regardless of blanking; in guard cycles dp SHALL be 1.
REQ-017 SHALL contain no combinational path from any input to any output.

Reset
REQ-018 SHALL, on Reset=1 at a clock edge, clear cnt, idx and all shadow registers to 0.
REQ-019 SHALL set an, seg and dp to all ones and frame_done to 0 on that edge.
REQ-020 SHALL give Reset priority over a simultaneous load; the load is discarded.
REQ-021 SHALL, after Reset deasserts, start scanning at idx=0 with cnt=0 on the next edge.
REQ-022 SHALL, on Reset mid-slot, abandon the current slot and blank outputs from the next edge.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-023 SHALL cover: load value=16'h12AF, en=4'hF, dp=0 -> per slot one guard cycle (an=1111), then 3 cycles each of an=1110/seg=0001110, 1101/0001000, 1011/0100100, 0111/1111001.
REQ-024 SHALL cover: a full 16-cycle scan -> frame_done pulses once per 16 cycles, one cycle after the idx 3->0 tick.
REQ-025 SHALL cover: value=16'h0050, lzb_en=1 -> digits 3 and 2 show seg=1111111, digit 1 shows 0010010, digit 0 shows 1000000; value=0 -> only digit 0 shows 1000000.
REQ-026 SHALL cover: value changed with load=0 -> outputs unchanged; load mid-slot -> new seg two edges later, an timing undisturbed.
REQ-027 SHALL cover: Reset asserted mid-slot together with load -> next edge an=1111, seg=1111111, dp=1; shadow stays 0 after release.
REQ-028 SHALL cover: dp_mask=4'b0100, en_mask=4'b1011 -> digit 2 slot shows dp=0 with seg=1111111; dp=1 in the guard cycles.
